systolic_host_sequencer: RTL and testbench
==========================================

# systolic_host_sequencer

Host-side driver for the nibble-serial 4x4 systolic array port. It holds one weight matrix and one input matrix in local registers written by the host. On `start` it streams both matrices into the array, issues the store strobe, and collects the 16 results into a readable buffer. It sits between the chip-level control logic and the systolic array, and drives the array's load/store strobes and data nibble.

## Interface
- `BITWIDTH`, 4, width of one matrix element / `sa_data`
- `OUTWIDTH`, 8, width of one result / `sa_results`
- `TIMEOUT`, 64, max idle cycles in COLLECT before abort (≥2)
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low; deassertion synchronous to `clk`
- `cfg_we`  in  1  write strobe for matrix registers
- `cfg_addr`  in  5  0–15 weights, 16–31 inputs, row-major
- `cfg_wdata`  in  BITWIDTH  element value
- `start`  in  1  begin one matrix pass (sampled in IDLE only)
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse when pass ends (normal or timeout)
- `err`  out  1  sticky timeout flag, cleared by next accepted `start`
- `res_addr`  in  4  result buffer read index
- `res_rdata`  out  OUTWIDTH  `res[res_addr]`, registered, 1-cycle latency
- `sa_data`  out  BITWIDTH  element nibble to array
- `sa_load_weights`, `sa_load_inputs`, `sa_store_outputs`  out  1 each  array strobes
- `sa_results`  in  OUTWIDTH  result from array
- `sa_valid`  in  1  `sa_results` valid this cycle

## Operation
- States: IDLE → LOAD_W → LOAD_I → STORE → COLLECT → IDLE.
- IDLE:
  - `cfg_we` writes `cfg_wdata` into `w[addr]` (addr <16) or `x[addr-16]`.
  - `start` clears `err` and the element counter `k`, then enters LOAD_W.
  - If `start` and `cfg_we` coincide, `start` wins and the write is dropped.
- LOAD_W: 16 cycles with `sa_load_weights`=1 and `sa_data`=`w[k]`, k=0..15, then go to LOAD_I.
- LOAD_I: 16 cycles with `sa_load_inputs`=1 and `sa_data`=`x[k]`, then go to STORE.
- STORE: 1 cycle with `sa_store_outputs`=1, then go to COLLECT with k=0 and timeout counter=0.
- COLLECT:
  - Each cycle `sa_valid`=1: `res[k]`←`sa_results`, k++, timeout counter cleared.
  - Each cycle `sa_valid`=0: timeout counter++.
  - After `res[15]` is captured: go to IDLE and pulse `done`.
  - If the counter reaches TIMEOUT: set `err`, pulse `done`, go to IDLE. Results already captured stay; the rest of `res` keeps its old values.
- `sa_valid` outside COLLECT is ignored.
- `cfg_we` and `start` while `busy` are ignored, with no side effects.
- `res_addr` reads are legal at any time and return current buffer contents.
- Strobes are mutually exclusive. `sa_data`=0 whenever neither load strobe is high.
- No arithmetic beyond counters. `k` is 4 bits and wraps only at state exit. The timeout counter saturates at TIMEOUT.

## Timing
- All outputs are registered.
- Reset values: `busy`=0, `done`=0, `err`=0, `res_rdata`=0, `sa_data`=0, all strobes 0. `w`, `x`, `res` are cleared to 0 and state is IDLE.
- With `start` sampled at edge t:
  - `busy`=1 and `sa_load_weights`=1 from cycle t+1.
  - Weights are presented in cycles t+1..t+16, inputs in t+17..t+32.
  - `sa_store_outputs`=1 in cycle t+33 only.
  - COLLECT begins at t+34.
- A result sampled at edge c is readable via `res_rdata` from c+1 (address applied at c+1, data at c+2).
- `done` goes high in the cycle after the 16th capture or the timeout hit. `busy` falls in that same cycle.
- Back-to-back passes: a `start` asserted while `done`=1 (state IDLE) is accepted.
- Reset mid-pass: all outputs drop to reset values immediately (async). No `done` pulse. The next pass requires a new `start`.

## Test plan
- Write w[k]=k, x[k]=15-k, then `start` → `sa_data` shows 0..15 under `sa_load_weights` at t+1..t+16, then 15..0 under `sa_load_inputs`, then `sa_store_outputs` exactly at t+33.
- In COLLECT, return `sa_results`=8'h10+k with `sa_valid` gapped (1,0,0,1,…) → `res[0..15]`=8'h10..8'h1F, `done` single pulse, `err`=0.
- Never assert `sa_valid` after STORE → `err`=1 and `done` pulse exactly TIMEOUT cycles after COLLECT entry; `res` unchanged; the next `start` clears `err`.
- `cfg_we` to addr 3 with data 4'hA while busy, and `start` with `cfg_we` in the same IDLE cycle → `w[3]` unchanged; the second pass streams old values.
- Assert `rst_n`=0 at t+20, release, then `start` → all outputs 0 during reset; the new pass starts cleanly from weight 0 (=0 after reset).
- Hold `start` high continuously → passes run back-to-back, with one `done` per 50-cycle-minimum pass and no strobe overlap.

Source files
------------

// File: rtl/systolic_host_sequencer.sv
// Host-side sequencer for the nibble-serial 4x4 systolic array: streams the
// stored weight/input matrices, strobes the store, then gathers 16 results.
module systolic_host_sequencer #(
  parameter int unsigned BITWIDTH = 4,
  parameter int unsigned OUTWIDTH = 8,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_we_i,
  input  logic [4:0]          cfg_addr_i,
  input  logic [BITWIDTH-1:0] cfg_wdata_i,
  input  logic                start_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  input  logic [3:0]          res_addr_i,
  output logic [OUTWIDTH-1:0] res_rdata_o,
  output logic [BITWIDTH-1:0] sa_data_o,
  output logic                sa_load_weights_o,
  output logic                sa_load_inputs_o,
  output logic                sa_store_outputs_o,
  input  logic [OUTWIDTH-1:0] sa_results_i,
  input  logic                sa_valid_i
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [3:0]    K_LAST   = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_W  = 3'd1,
    S_LOAD_I  = 3'd2,
    S_STORE   = 3'd3,
    S_COLLECT = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          k_q, k_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                err_q, err_d;
  logic                wr_en_s, cap_en_s;
  logic [BITWIDTH-1:0] data_d;
  logic                done_d;

  logic                busy_q, done_q, lw_q, li_q, so_q;
  logic [BITWIDTH-1:0] data_q;
  logic [OUTWIDTH-1:0] rdata_q;

  logic [BITWIDTH-1:0] w_q   [16];
  logic [BITWIDTH-1:0] x_q   [16];
  logic [OUTWIDTH-1:0] res_q [16];

  // Next-state, counter and control-strobe decode.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    wr_en_s  = 1'b0;
    cap_en_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_LOAD_W;
          k_d     = 4'd0;
          err_d   = 1'b0;
        end else begin
          wr_en_s = cfg_we_i;
        end
      end
      S_LOAD_W: begin
        if (k_q == K_LAST) begin
          state_d = S_LOAD_I;
          k_d     = 4'd0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_LOAD_I: begin
        if (k_q == K_LAST) begin
          state_d = S_STORE;
          k_d     = 4'd0;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      S_STORE: begin
        state_d = S_COLLECT;
        k_d     = 4'd0;
        tmo_d   = {TW{1'b0}};
      end
      S_COLLECT: begin
        if (sa_valid_i) begin
          cap_en_s = 1'b1;
          tmo_d    = {TW{1'b0}};
          if (k_q == K_LAST) begin
            state_d = S_IDLE;
            k_d     = 4'd0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end else if (tmo_q >= TMO_LAST) begin
          // The idle cycle that brings the count to TIMEOUT aborts the pass.
          tmo_d   = TMO_MAX;
          err_d   = 1'b1;
          state_d = S_IDLE;
          k_d     = 4'd0;
        end else begin
          tmo_d = tmo_q + {{(TW-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = S_IDLE;
        k_d     = 4'd0;
      end
    endcase

    done_d = (state_q == S_COLLECT) && (state_d == S_IDLE);

    if (state_d == S_LOAD_W) begin
      data_d = w_q[k_d];
    end else if (state_d == S_LOAD_I) begin
      data_d = x_q[k_d];
    end else begin
      data_d = {BITWIDTH{1'b0}};
    end
  end

  // State, counters and registered outputs, aligned to the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      k_q     <= 4'd0;
      tmo_q   <= {TW{1'b0}};
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lw_q    <= 1'b0;
      li_q    <= 1'b0;
      so_q    <= 1'b0;
      data_q  <= {BITWIDTH{1'b0}};
      rdata_q <= {OUTWIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      lw_q    <= (state_d == S_LOAD_W);
      li_q    <= (state_d == S_LOAD_I);
      so_q    <= (state_d == S_STORE);
      data_q  <= data_d;
      rdata_q <= res_q[res_addr_i];
    end
  end

  // Matrix registers and result buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) begin
        w_q[i]   <= {BITWIDTH{1'b0}};
        x_q[i]   <= {BITWIDTH{1'b0}};
        res_q[i] <= {OUTWIDTH{1'b0}};
      end
    end else begin
      if (wr_en_s) begin
        if (cfg_addr_i[4]) begin
          x_q[cfg_addr_i[3:0]] <= cfg_wdata_i;
        end else begin
          w_q[cfg_addr_i[3:0]] <= cfg_wdata_i;
        end
      end
      if (cap_en_s) begin
        res_q[k_q] <= sa_results_i;
      end
    end
  end

  assign busy_o             = busy_q;
  assign done_o             = done_q;
  assign err_o              = err_q;
  assign res_rdata_o        = rdata_q;
  assign sa_data_o          = data_q;
  assign sa_load_weights_o  = lw_q;
  assign sa_load_inputs_o   = li_q;
  assign sa_store_outputs_o = so_q;

endmodule

// File: tb/tb_systolic_host_sequencer.sv
// Randomized self-checking bench for systolic_host_sequencer; expectations come
// from a pass-level model (matrix arrays, capture count, idle-gap count).
module tb_systolic_host_sequencer;
  localparam int BW = 4;
  localparam int OW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          cfg_we = 1'b0;
  logic [4:0]    cfg_addr = 5'd0;
  logic [BW-1:0] cfg_wdata = 4'd0;
  logic          start = 1'b0;
  logic          busy, done, err;
  logic [3:0]    res_addr = 4'd0;
  logic [OW-1:0] res_rdata;
  logic [BW-1:0] sa_data;
  logic          lw, li, so;
  logic [OW-1:0] sa_results = 8'd0;
  logic          sa_valid = 1'b0;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] w_m   [16];
  logic [BW-1:0] x_m   [16];
  logic [OW-1:0] res_m [16];
  logic          err_m;

  systolic_host_sequencer #(.BITWIDTH(BW), .OUTWIDTH(OW), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .start_i(start), .busy_o(busy), .done_o(done),
    .err_o(err), .res_addr_i(res_addr), .res_rdata_o(res_rdata),
    .sa_data_o(sa_data), .sa_load_weights_o(lw), .sa_load_inputs_o(li),
    .sa_store_outputs_o(so), .sa_results_i(sa_results), .sa_valid_i(sa_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {busy, done, err, lw, li, so, sa_data};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      w_m[i] = 4'd0; x_m[i] = 4'd0; res_m[i] = 8'd0;
    end
    err_m = 1'b0;
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [BW-1:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    step();
    cfg_we = 1'b0;
    if (a < 5'd16) w_m[a[3:0]] = d;
    else x_m[a[3:0]] = d;
  endtask

  // mode 0: random gaps incl. one TO-1 gap, 1: pattern 1,0,0 with 8'h10+k, 2: never valid
  task automatic do_pass(input int mode, input bit hold, input bit readback, input bit collide);
    logic [9:0]    e;
    logic [OW-1:0] v;
    bit            vld, fin;
    int            caps, idle;
    start = 1'b1;
    if (collide) begin
      cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 4'hA;
    end
    step();
    start = hold; cfg_we = 1'b0;
    err_m = 1'b0;
    for (int i = 0; i < 33; i++) begin
      if (i < 16) e = {1'b1, 1'b0, err_m, 1'b1, 1'b0, 1'b0, w_m[i]};
      else if (i < 32) e = {1'b1, 1'b0, err_m, 1'b0, 1'b1, 1'b0, x_m[i-16]};
      else e = {1'b1, 1'b0, err_m, 1'b0, 1'b0, 1'b1, 4'd0};
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL stream cyc=%0d got=%b required=%b", i + 1, obs(), e);
      end
      cfg_we = 1'($urandom_range(0, 1)); cfg_addr = 5'($urandom); cfg_wdata = 4'($urandom);
      if (i == 5) begin
        cfg_we = 1'b1; cfg_addr = 5'd3; cfg_wdata = 4'hA;
      end
      sa_valid = 1'($urandom_range(0, 1)); sa_results = 8'($urandom);
      if (!hold) start = 1'($urandom_range(0, 1));
      step();
    end
    cfg_we = 1'b0; sa_valid = 1'b0;
    if (!hold) start = 1'b0;
    caps = 0; idle = 0; fin = 1'b0;
    for (int c = 0; c < 400 && !fin; c++) begin
      e = {1'b1, 1'b0, err_m, 7'd0};
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL collect cyc=%0d got=%b required=%b", c, obs(), e);
      end
      if (mode == 1) vld = (c % 3 == 0);
      else if (mode == 2) vld = 1'b0;
      else if (idle == TO - 1) vld = 1'b1;
      else if (caps == 5) vld = 1'b0;
      else vld = ($urandom_range(0, 2) != 0);
      v = (mode == 1) ? 8'(8'h10 + caps) : 8'($urandom);
      sa_valid = vld; sa_results = v;
      step();
      if (vld) begin
        res_m[caps] = v; caps++; idle = 0;
      end else begin
        idle++;
      end
      if (caps == 16) fin = 1'b1;
      if (idle == TO) begin
        fin = 1'b1; err_m = 1'b1;
      end
    end
    sa_valid = 1'b0;
    e = {1'b0, 1'b1, err_m, 7'd0};
    total++;
    if (!fin || obs() !== e) begin
      bad++;
      $display("FAIL done_cycle finished=%0d got=%b required=%b", fin, obs(), e);
    end
    if (!hold) begin
      sa_valid = 1'b1; sa_results = 8'($urandom);
      step();
      sa_valid = 1'b0;
      e = {1'b0, 1'b0, err_m, 7'd0};
      total++;
      if (obs() !== e) begin
        bad++;
        $display("FAIL after_done got=%b required=%b", obs(), e);
      end
    end
    if (readback) begin
      for (int a = 0; a < 16; a++) begin
        res_addr = 4'(a);
        step();
        total++;
        if (res_rdata !== res_m[a]) begin
          bad++;
          $display("FAIL res[%0d] got=%h required=%h", a, res_rdata, res_m[a]);
        end
      end
    end
  endtask

  task automatic test_reset();
    model_clear();
    #3;
    total++;
    if (obs() !== 10'd0 || res_rdata !== 8'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b/%h required=0", obs(), res_rdata);
    end
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int a = 0; a < 16; a++) begin
      res_addr = 4'(a);
      step();
      total++;
      if (res_rdata !== 8'd0 || obs() !== 10'd0) begin
        bad++;
        $display("FAIL reset_res[%0d] got=%h/%b required=0", a, res_rdata, obs());
      end
    end
  endtask

  task automatic test_stream_gapped();
    for (int k = 0; k < 16; k++) cfg_write(5'(k), 4'(k));
    for (int k = 0; k < 16; k++) cfg_write(5'(16 + k), 4'(15 - k));
    do_pass(1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_timeout();
    do_pass(2, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_collision();
    do_pass(0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midpass();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 19; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    total++;
    if (obs() !== 10'd0 || res_rdata !== 8'd0) begin
      bad++;
      $display("FAIL midpass_reset got=%b/%h required=0", obs(), res_rdata);
    end
    step(); step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if (obs() !== 10'd0) begin
        bad++;
        $display("FAIL post_reset_idle cyc=%0d got=%b required=0", i, obs());
      end
    end
    do_pass(0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) cfg_write(5'($urandom), 4'($urandom));
    do_pass(0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cfg_write(5'($urandom), 4'($urandom));
    do_pass(0, 1'b1, 1'b0, 1'b0);
    do_pass(1, 1'b1, 1'b0, 1'b0);
    do_pass(0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_stream_gapped();
    test_timeout();
    test_collision();
    test_reset_midpass();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
